// File: rtl/instr_sequencer_if.sv
// Bus between the instruction fetch/memory side and the multi-cycle instruction sequencer.
// The sequencer takes the slave view; the fetch unit (or a testbench) takes the master view.
interface instr_sequencer_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        mem_ready;
    logic [9:0]  code;
    logic [31:0] ir;
    logic [2:0]  state;
    logic        fetch_req;
    logic        ir_write;
    logic        mem_req;
    logic        mem_we;
    logic        reg_write;
    logic        pc_write;
    logic        illegal;
    logic [31:0] instret;

    modport master (
        output instr, instr_valid, mem_ready,
        input  code, ir, state, fetch_req, ir_write, mem_req, mem_we,
               reg_write, pc_write, illegal, instret
    );

    modport slave (
        input  instr, instr_valid, mem_ready,
        output code, ir, state, fetch_req, ir_write, mem_req, mem_we,
               reg_write, pc_write, illegal, instret
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle RV32 instruction sequencer: latches the fetched word, classifies its opcode
// one-hot, and steps FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK while counting retirements.
module instr_sequencer (
    input  logic              clk,
    input  logic              rst_n,
    instr_sequencer_if.slave  sq
);

    localparam logic [2:0] FETCH     = 3'd0;
    localparam logic [2:0] DECODE    = 3'd1;
    localparam logic [2:0] EXECUTE   = 3'd2;
    localparam logic [2:0] MEMORY    = 3'd3;
    localparam logic [2:0] WRITEBACK = 3'd4;

    logic [2:0]  state_q;
    logic [2:0]  state_d;
    logic [31:0] ir_q;
    logic [9:0]  code_q;
    logic [31:0] instret_q;
    logic        ir_load;
    logic        fetch_req_c;
    logic        ir_write_c;
    logic        mem_req_c;
    logic        mem_we_c;
    logic        reg_write_c;
    logic        pc_write_c;
    logic        illegal_c;

    function automatic logic [9:0] decode_opcode(input logic [6:0] op);
        logic [9:0] c;
        c = 10'b0;
        case (op)
            7'b1101111: c[0] = 1'b1;
            7'b1100111: c[1] = 1'b1;
            7'b0110111: c[2] = 1'b1;
            7'b0010111: c[3] = 1'b1;
            7'b1100011: c[4] = 1'b1;
            7'b0110011: c[5] = 1'b1;
            7'b0100011: c[6] = 1'b1;
            7'b0010011: c[7] = 1'b1;
            7'b0000011: c[8] = 1'b1;
            7'b1110011: c[9] = 1'b1;
            default:    c    = 10'b0;
        endcase
        return c;
    endfunction

    assign ir_load = (state_q == FETCH) && sq.instr_valid;

    // Strobes are purely combinational; ir_write is gated with rst_n so nothing
    // looks like a capture while reset is held.
    always_comb begin
        state_d     = state_q;
        fetch_req_c = 1'b0;
        ir_write_c  = 1'b0;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        reg_write_c = 1'b0;
        pc_write_c  = 1'b0;
        illegal_c   = 1'b0;
        case (state_q)
            FETCH: begin
                fetch_req_c = 1'b1;
                ir_write_c  = sq.instr_valid & rst_n;
                if (sq.instr_valid) state_d = DECODE;
            end
            DECODE: begin
                if (code_q == 10'b0) begin
                    illegal_c = 1'b1;
                    state_d   = FETCH;
                end else begin
                    state_d   = EXECUTE;
                end
            end
            EXECUTE: begin
                if (code_q[8] || code_q[6]) begin
                    state_d = MEMORY;
                end else if (code_q[4]) begin
                    pc_write_c = 1'b1;
                    state_d    = FETCH;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            MEMORY: begin
                mem_req_c = 1'b1;
                mem_we_c  = code_q[6];
                if (sq.mem_ready) begin
                    if (code_q[6]) begin
                        pc_write_c = 1'b1;
                        state_d    = FETCH;
                    end else begin
                        state_d    = WRITEBACK;
                    end
                end
            end
            WRITEBACK: begin
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                state_d     = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // ir and code are captured together so code always describes the word in ir.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q   <= 32'b0;
            code_q <= 10'b0;
        end else if (ir_load) begin
            ir_q   <= sq.instr;
            code_q <= decode_opcode(sq.instr[6:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          instret_q <= 32'b0;
        else if (pc_write_c) instret_q <= instret_q + 32'd1;
    end

    assign sq.state     = state_q;
    assign sq.ir        = ir_q;
    assign sq.code      = code_q;
    assign sq.instret   = instret_q;
    assign sq.fetch_req = fetch_req_c;
    assign sq.ir_write  = ir_write_c;
    assign sq.mem_req   = mem_req_c;
    assign sq.mem_we    = mem_we_c;
    assign sq.reg_write = reg_write_c;
    assign sq.pc_write  = pc_write_c;
    assign sq.illegal   = illegal_c;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle state/strobe vectors and retirement counts
// for every instruction class, wait states, illegal opcodes, mid-instruction reset and wrap.
module tb_instr_sequencer;

    logic clk;
    logic rst_n;
    int   check_count;
    int   pass_count;
    logic [31:0] exp_instret;

    instr_sequencer_if bus ();

    instr_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sq    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe vector order: fetch_req, ir_write, mem_req, mem_we, reg_write, pc_write, illegal
    localparam logic [6:0] S_FETCH_V = 7'b1100000;
    localparam logic [6:0] S_FETCH_I = 7'b1000000;
    localparam logic [6:0] S_NONE    = 7'b0000000;
    localparam logic [6:0] S_ILLEGAL = 7'b0000001;
    localparam logic [6:0] S_BRANCH  = 7'b0000010;
    localparam logic [6:0] S_MEM_RD  = 7'b0010000;
    localparam logic [6:0] S_MEM_WR  = 7'b0011010;
    localparam logic [6:0] S_WB      = 7'b0000110;

    logic [6:0] strobes;
    assign strobes = {bus.fetch_req, bus.ir_write, bus.mem_req, bus.mem_we,
                      bus.reg_write, bus.pc_write, bus.illegal};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp)
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        else
            pass_count++;
    endtask

    task automatic applyStimulus(input logic [31:0] i, input logic v, input logic r);
        @(negedge clk);
        bus.instr       = i;
        bus.instr_valid = v;
        bus.mem_ready   = r;
        #1;
    endtask

    task automatic cycleCheck(input string tag, input logic [31:0] i, input logic v, input logic r,
                              input logic [2:0] st, input logic [6:0] strb);
        applyStimulus(i, v, r);
        checkOutput({tag, " state"}, {29'b0, bus.state}, {29'b0, st});
        checkOutput({tag, " strobes"}, {25'b0, strobes}, {25'b0, strb});
    endtask

    task automatic idleFetch(input string tag);
        cycleCheck(tag, 32'h0, 1'b0, 1'b0, 3'd0, S_FETCH_I);
        checkOutput({tag, " instret"}, bus.instret, exp_instret);
    endtask

    // Four-cycle classes; DECODE is driven with a junk valid word to show it is ignored.
    task automatic runFourCycle(input string tag, input logic [31:0] i, input logic [9:0] c);
        cycleCheck({tag, " F"}, i, 1'b1, 1'b0, 3'd0, S_FETCH_V);
        cycleCheck({tag, " D"}, 32'hFFFF_FFFF, 1'b1, 1'b1, 3'd1, S_NONE);
        checkOutput({tag, " code"}, {22'b0, bus.code}, {22'b0, c});
        checkOutput({tag, " ir"}, bus.ir, i);
        cycleCheck({tag, " E"}, 32'h0, 1'b0, 1'b1, 3'd2, S_NONE);
        cycleCheck({tag, " W"}, 32'h0, 1'b0, 1'b1, 3'd4, S_WB);
        exp_instret = exp_instret + 32'd1;
    endtask

    logic [31:0] alu_instr [7];
    logic [9:0]  alu_code  [7];

    initial begin
        check_count = 0;
        pass_count  = 0;
        exp_instret = 32'd0;
        alu_instr[0] = 32'h0000_00B7; alu_code[0] = 10'b0000000100;
        alu_instr[1] = 32'h0000_0097; alu_code[1] = 10'b0000001000;
        alu_instr[2] = 32'h0000_006F; alu_code[2] = 10'b0000000001;
        alu_instr[3] = 32'h0000_0067; alu_code[3] = 10'b0000000010;
        alu_instr[4] = 32'h0000_0033; alu_code[4] = 10'b0000100000;
        alu_instr[5] = 32'h0000_0073; alu_code[5] = 10'b1000000000;
        alu_instr[6] = 32'h0020_8113; alu_code[6] = 10'b0010000000;

        rst_n           = 1'b0;
        bus.instr       = 32'h0050_0093;
        bus.instr_valid = 1'b1;
        bus.mem_ready   = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("reset state", {29'b0, bus.state}, 32'd0);
        checkOutput("reset code", {22'b0, bus.code}, 32'd0);
        checkOutput("reset ir", bus.ir, 32'd0);
        checkOutput("reset instret", bus.instret, 32'd0);
        checkOutput("reset strobes", {25'b0, strobes}, {25'b0, S_FETCH_I});
        bus.instr_valid = 1'b0;
        rst_n           = 1'b1;

        idleFetch("idle");

        // ADDI: 0,1,2,4,0
        runFourCycle("addi", 32'h0050_0093, 10'b0010000000);
        idleFetch("addi done");

        // LW with two wait cycles
        cycleCheck("lw F", 32'h0000_2083, 1'b1, 1'b0, 3'd0, S_FETCH_V);
        cycleCheck("lw D", 32'h0, 1'b0, 1'b0, 3'd1, S_NONE);
        checkOutput("lw code", {22'b0, bus.code}, {22'b0, 10'b0100000000});
        cycleCheck("lw E", 32'h0, 1'b0, 1'b0, 3'd2, S_NONE);
        cycleCheck("lw M0", 32'h0, 1'b0, 1'b0, 3'd3, S_MEM_RD);
        cycleCheck("lw M1", 32'h0, 1'b0, 1'b0, 3'd3, S_MEM_RD);
        cycleCheck("lw M2", 32'h0, 1'b0, 1'b1, 3'd3, S_MEM_RD);
        cycleCheck("lw W", 32'h0, 1'b0, 1'b0, 3'd4, S_WB);
        exp_instret = exp_instret + 32'd1;
        idleFetch("lw done");

        // SW with no wait, then BEQ straight after
        cycleCheck("sw F", 32'h0011_2023, 1'b1, 1'b0, 3'd0, S_FETCH_V);
        cycleCheck("sw D", 32'h0, 1'b0, 1'b0, 3'd1, S_NONE);
        checkOutput("sw code", {22'b0, bus.code}, {22'b0, 10'b0001000000});
        cycleCheck("sw E", 32'h0, 1'b0, 1'b1, 3'd2, S_NONE);
        cycleCheck("sw M", 32'h0, 1'b0, 1'b1, 3'd3, S_MEM_WR);
        exp_instret = exp_instret + 32'd1;
        cycleCheck("beq F", 32'h0000_0063, 1'b1, 1'b0, 3'd0, S_FETCH_V);
        cycleCheck("beq D", 32'h0, 1'b0, 1'b0, 3'd1, S_NONE);
        checkOutput("beq code", {22'b0, bus.code}, {22'b0, 10'b0000010000});
        cycleCheck("beq E", 32'h0, 1'b0, 1'b0, 3'd2, S_BRANCH);
        exp_instret = exp_instret + 32'd1;
        idleFetch("sw beq done");

        // Illegal opcode: one-cycle illegal in DECODE, no retirement
        cycleCheck("ill F", 32'h0, 1'b1, 1'b0, 3'd0, S_FETCH_V);
        cycleCheck("ill D", 32'h0, 1'b0, 1'b0, 3'd1, S_ILLEGAL);
        checkOutput("ill code", {22'b0, bus.code}, 32'd0);
        idleFetch("ill done");
        idleFetch("ill quiet");

        for (int k = 0; k < 7; k++) begin
            runFourCycle($sformatf("class%0d", k), alu_instr[k], alu_code[k]);
        end
        idleFetch("classes done");

        // Reset pulse while an SW waits in MEMORY
        cycleCheck("rsw F", 32'h0011_2023, 1'b1, 1'b0, 3'd0, S_FETCH_V);
        cycleCheck("rsw D", 32'h0, 1'b0, 1'b0, 3'd1, S_NONE);
        cycleCheck("rsw E", 32'h0, 1'b0, 1'b0, 3'd2, S_NONE);
        cycleCheck("rsw M", 32'h0, 1'b0, 1'b0, 3'd3, S_MEM_WR & 7'b0010000 | 7'b0001000);
        #1 rst_n = 1'b0;
        #1;
        exp_instret = 32'd0;
        checkOutput("rst mid state", {29'b0, bus.state}, 32'd0);
        checkOutput("rst mid code", {22'b0, bus.code}, 32'd0);
        checkOutput("rst mid mem_we", {31'b0, bus.mem_we}, 32'd0);
        checkOutput("rst mid mem_req", {31'b0, bus.mem_req}, 32'd0);
        checkOutput("rst mid instret", bus.instret, 32'd0);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        rst_n         = 1'b1;
        runFourCycle("post rst", 32'h0050_0093, 10'b0010000000);
        idleFetch("post rst done");

        // Counter wrap from all-ones on the next retirement
        applyStimulus(32'h0, 1'b0, 1'b0);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1 release dut.instret_q;
        #1;
        exp_instret = 32'hFFFF_FFFF;
        checkOutput("wrap preload", bus.instret, exp_instret);
        cycleCheck("wrap F", 32'h0000_0063, 1'b1, 1'b0, 3'd0, S_FETCH_V);
        cycleCheck("wrap D", 32'h0, 1'b0, 1'b0, 3'd1, S_NONE);
        cycleCheck("wrap E", 32'h0, 1'b0, 1'b0, 3'd2, S_BRANCH);
        exp_instret = exp_instret + 32'd1;
        idleFetch("wrap done");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
